vcode_stream_gen: RTL
=====================

Name: vcode_stream_gen

Overview:
- TX-side verification-code generator with valid/ready handshake, the streaming successor of the free-running per-beat code generator.
- Accepts frames of FRAME_WIDTH bits as FRAME_WIDTH/DWIDTH beats and computes a CRC over each frame.
- Overwrites the low CRC_WIDTH bits of each frame's tail beat with CRC XOR the running frame ID.
- Sits between the TX framer and the scrambler/gearbox. Tolerates backpressure and detects malformed framing.

Parameters:
- FRAME_WIDTH, 256: frame size in bits. Must be a power-of-2 multiple of DWIDTH.
- DWIDTH, 64: beat width.
- CRC_WIDTH, 12: code width.
- CRC_POLY, 12'h02f: normal-representation polynomial, x^CRC_WIDTH term implicit.
- FRAME_ID_WIDTH, 8: frame ID counter width. Must be <= CRC_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid&&s_ready
- s_sof  in  1  beat is first of a frame
- s_data  in  DWIDTH  input beat; bits [DWIDTH-1-:2]==2'b01 on the sof beat marks a data frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_sof  out  1  registered copy of s_sof
- m_data  out  DWIDTH  output beat
- frame_id  out  FRAME_ID_WIDTH  current frame ID
- proto_err  out  1  one-cycle pulse on framing violation

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: m_valid=0, m_sof=0, m_data=0, frame_id=0, proto_err=0, CRC accumulator=0, beat counter=0, state IDLE.
- Handshake: single output register, so s_ready = !m_valid || m_ready. An accepted beat appears on m_* the next cycle (latency 1).
- m_data/m_sof hold while m_valid && !m_ready. No state advances without an input handshake.
- BEATS = FRAME_WIDTH/DWIDTH. A beat counter counts accepted beats 0..BEATS-1; the tail beat is beat BEATS-1.
- CRC: serial LFSR, MSB-first over s_data[DWIDTH-1] down to s_data[0]. Per bit: fb = crc[CRC_WIDTH-1]^bit; shift left; bit0 = fb; XOR fb into bit j for each CRC_POLY[j]=1 with j>=1.
- CRC init is 0 per frame and covers all beats, including the tail beat's low CRC_WIDTH bits as received.
- The CRC chain is combinational across one beat and registered only between beats.
- Tail beat output: {s_data[DWIDTH-1:CRC_WIDTH], crc_final ^ zero-extended frame_id}. Non-tail beats pass unchanged.
- Every frame, data or control, gets the code on its tail beat.
- frame_id increments by 1 after the tail of a data frame is accepted. It wraps modulo 2^FRAME_ID_WIDTH. Control frames do not increment it.
- State IDLE: accepted beat with s_sof=1 starts a frame.
  - BEATS=1: the beat is also the tail; stay IDLE.
  - Otherwise go to BODY, counter=1.
- State BODY: each accepted beat increments the counter. The tail beat returns to IDLE and clears the CRC.
- Violation, IDLE beat with s_sof=0: pass unchanged, no CRC, proto_err pulses the cycle after acceptance.
- Violation, s_sof=1 in BODY: abort the current frame (no code written, frame_id unchanged), pulse proto_err, restart as a new frame from that beat (counter=1, CRC reseeded from 0).
- Reset mid-frame: partial frame discarded, nothing emitted afterwards for it.

Optional Feature:
- Macro: VCODE_ERR_INJECT_EN.
- When defined: adds input err_inject (1 bit). A pulse arms a sticky flag. The next data-frame tail has bit 0 of its code field inverted, then the flag clears. Arming while already armed has no extra effect.
- When undefined: no port, no flag, codes always correct.

Test Plan:
- BEATS=4, control frame of all-zero beats (header 2'b00), frame_id=0 -> tail m_data=0, frame_id stays 0, proto_err=0.
- 3 data frames (header 2'b01, rest random) back-to-back, m_ready=1 -> each tail low 12 bits equal the model CRC ^ {4'b0, id}, with id=0,1,2; frame_id=3 afterwards; one beat per cycle throughput.
- Same traffic with m_ready toggling randomly 50% -> output identical to the m_ready=1 run; m_data stable while m_valid&&!m_ready; no beat lost or duplicated.
- 256+1 data frames from reset -> frame_id wraps 255->0; tail of frame 256 XORs with id 0.
- s_sof reasserted at beat 2 of a data frame -> proto_err pulses once, aborted frame has no code, new frame coded with unchanged frame_id. Beat without sof in IDLE -> passes unchanged, proto_err=1.
- rst_n low at beat 2 for 1 cycle -> m_valid=0 and frame_id=0 immediately (async). The next full frame is coded with id 0 and CRC from 0.

Source files
------------

// File: rtl/vcode_stream_gen.sv
// vcode_stream_gen: valid/ready frame CRC coder that writes CRC^frame_id into each frame's tail beat.
// Optional VCODE_ERR_INJECT_EN adds err_inject to corrupt bit 0 of the next data-frame code.
module vcode_stream_gen #(
    parameter int                   FRAME_WIDTH    = 256,
    parameter int                   DWIDTH         = 64,
    parameter int                   CRC_WIDTH      = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY       = 12'h02f,
    parameter int                   FRAME_ID_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef VCODE_ERR_INJECT_EN
    input  logic                      err_inject,
`endif
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_sof,
    input  logic [DWIDTH-1:0]         s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sof,
    output logic [DWIDTH-1:0]         m_data,
    output logic [FRAME_ID_WIDTH-1:0] frame_id,
    output logic                      proto_err
);
    localparam int BEATS = FRAME_WIDTH / DWIDTH;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic {IDLE, BODY} state_t;
    state_t r_state, w_state_nxt;

    logic [CRC_WIDTH-1:0]      r_crc, w_crc, w_code;
    logic [CW-1:0]             r_cnt, w_idx;
    logic [FRAME_ID_WIDTH-1:0] r_fid;
    logic                      r_is_data, r_m_valid, r_m_sof, r_perr;
    logic [DWIDTH-1:0]         r_m_data, w_out;
    logic                      w_acc, w_in_frame, w_tail, w_data_frm, w_perr, w_inj;

    function automatic logic [CRC_WIDTH-1:0] f_crc(input logic [CRC_WIDTH-1:0] seed,
                                                   input logic [DWIDTH-1:0] d);
        logic [CRC_WIDTH-1:0] c;
        logic fb;
        c = seed;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ d[i];
            c  = {c[CRC_WIDTH-2:0], fb} ^ ({CRC_WIDTH{fb}} & {CRC_POLY[CRC_WIDTH-1:1], 1'b0});
        end
        return c;
    endfunction

    assign s_ready   = !r_m_valid || m_ready;
    assign w_acc     = s_valid && s_ready;
    assign m_valid   = r_m_valid;
    assign m_sof     = r_m_sof;
    assign m_data    = r_m_data;
    assign frame_id  = r_fid;
    assign proto_err = r_perr;

`ifdef VCODE_ERR_INJECT_EN
    logic r_armed;
    assign w_inj = r_armed && w_tail && w_data_frm;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_armed <= 1'b0;
        else        r_armed <= (r_armed && !(w_acc && w_inj)) || err_inject;
`else
    assign w_inj = 1'b0;
`endif

    // A sof beat always opens a fresh frame, so it restarts the index and CRC seed.
    always_comb begin
        w_in_frame  = s_sof || (r_state == BODY);
        w_idx       = s_sof ? '0 : r_cnt;
        w_tail      = w_in_frame && (w_idx == LAST);
        w_data_frm  = s_sof ? (s_data[DWIDTH-1 -: 2] == 2'b01) : r_is_data;
        w_crc       = f_crc(s_sof ? '0 : r_crc, s_data);
        w_code      = w_crc ^ CRC_WIDTH'(r_fid) ^ CRC_WIDTH'(w_inj);
        w_out       = w_tail ? {s_data[DWIDTH-1:CRC_WIDTH], w_code} : s_data;
        w_perr      = w_acc && (s_sof ? (r_state == BODY) : (r_state == IDLE));
        w_state_nxt = !w_acc ? r_state : (w_in_frame && !w_tail) ? BODY : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc     <= '0;
            r_cnt     <= '0;
            r_fid     <= '0;
            r_is_data <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_perr <= w_perr;
            if (w_acc && w_in_frame) begin
                r_crc <= w_tail ? '0 : w_crc;
                r_cnt <= w_tail ? '0 : w_idx + 1'b1;
            end
            if (w_acc && s_sof) r_is_data <= w_data_frm;
            if (w_acc && w_tail && w_data_frm) r_fid <= r_fid + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_sof   <= 1'b0;
            r_m_data  <= '0;
        end else if (s_ready) begin
            r_m_valid <= s_valid;
            if (s_valid) begin
                r_m_sof  <= s_sof;
                r_m_data <= w_out;
            end
        end
    end
endmodule
